// File: rtl/edge_tile_scan_ctrl.sv
// edge_tile_scan_ctrl
// Frame sequencer for the 4x4-tiled edge-detection array. It generates the
// shared tile-local scan coordinate and read strobe, and latches the threshold
// for the whole frame. A delay line aligns output-memory write enables with the
// detector outputs. A start/busy/done handshake is provided, together with
// hold (stall), abort and a completed-frame counter.
module edge_tile_scan_ctrl #(
    parameter int TILE   = 32,
    parameter int CW     = 5,
    parameter int ED_LAT = 1,
    parameter int FCW    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [7:0]     T,
    input  logic           hold,
    input  logic           abort,
    output logic [7:0]     thr_out,
    output logic [CW-1:0]  rd_row,
    output logic [CW-1:0]  rd_col,
    output logic           rd_valid,
    output logic           wr_en,
    output logic [CW-1:0]  wr_row,
    output logic [CW-1:0]  wr_col,
    output logic           busy,
    output logic           done,
    output logic [FCW-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0]  LAST_POS = CW'(TILE - 1);
    localparam logic [CW-1:0]  POS_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  POS_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [FCW-1:0] FC_ONE   = {{(FCW-1){1'b0}}, 1'b1};

    // Column-major-inner advance of the tile-local scan position.
    function automatic logic [2*CW-1:0] next_pos(input logic [CW-1:0] row,
                                                 input logic [CW-1:0] col);
        logic [CW-1:0] row_n;
        logic [CW-1:0] col_n;
        if (col == LAST_POS) begin
            col_n = POS_ZERO;
            row_n = row + POS_ONE;
        end else begin
            col_n = col + POS_ONE;
            row_n = row;
        end
        return {row_n, col_n};
    endfunction

    state_t          state_r;
    state_t          state_nx_s;
    logic            start_acc_s;
    logic            issue_s;
    logic            last_issue_s;
    logic            frame_end_s;
    logic            dl_upper_s;
    logic            dl_in_vld_s;
    logic [2*CW-1:0] pos_nx_s;

    logic [7:0]      thr_r;
    logic [CW-1:0]   rd_row_r;
    logic [CW-1:0]   rd_col_r;
    logic            rd_valid_r;
    logic            busy_r;
    logic            done_r;
    logic [FCW-1:0]  frame_cnt_r;

    logic [ED_LAT-1:0] dl_vld_r;
    logic [CW-1:0]     dl_row_r [ED_LAT];
    logic [CW-1:0]     dl_col_r [ED_LAT];

    // Any valid entry in all but the last delay stage means writes are still in flight.
    always_comb begin
        dl_upper_s = 1'b0;
        for (int i = 0; i < ED_LAT - 1; i++) begin
            dl_upper_s = dl_upper_s | dl_vld_r[i];
        end
    end

    // Next-state logic and per-cycle control strobes; abort outranks hold.
    always_comb begin
        state_nx_s   = state_r;
        start_acc_s  = 1'b0;
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        frame_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx_s  = ST_RUN;
                    start_acc_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (hold) begin
                    state_nx_s = ST_RUN;
                end else begin
                    issue_s = 1'b1;
                    if ((rd_row_r == LAST_POS) && (rd_col_r == LAST_POS)) begin
                        last_issue_s = 1'b1;
                        state_nx_s   = ST_DRAIN;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (hold) begin
                    state_nx_s = ST_DRAIN;
                end else if (!dl_upper_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s  = ST_IDLE;
                    frame_end_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign pos_nx_s    = next_pos(rd_row_r, rd_col_r);
    assign dl_in_vld_s = rd_valid_r & ~hold;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Threshold latch: captured only when a frame is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_r <= 8'd0;
        end else if (start_acc_s) begin
            thr_r <= T;
        end else begin
            thr_r <= thr_r;
        end
    end

    // Scan coordinate and read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_row_r   <= POS_ZERO;
            rd_col_r   <= POS_ZERO;
            rd_valid_r <= 1'b0;
        end else if (abort) begin
            rd_valid_r <= 1'b0;
        end else if (start_acc_s) begin
            rd_row_r   <= POS_ZERO;
            rd_col_r   <= POS_ZERO;
            rd_valid_r <= 1'b1;
        end else if (issue_s) begin
            rd_row_r   <= pos_nx_s[2*CW-1:CW];
            rd_col_r   <= pos_nx_s[CW-1:0];
            rd_valid_r <= ~last_issue_s;
        end else begin
            rd_valid_r <= rd_valid_r;
        end
    end

    // Detector-latency delay line; frozen by hold, flushed by abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_vld_r <= {ED_LAT{1'b0}};
            for (int i = 0; i < ED_LAT; i++) begin
                dl_row_r[i] <= POS_ZERO;
                dl_col_r[i] <= POS_ZERO;
            end
        end else if (abort) begin
            dl_vld_r <= {ED_LAT{1'b0}};
        end else if (!hold) begin
            dl_vld_r[0] <= dl_in_vld_s;
            dl_row_r[0] <= rd_row_r;
            dl_col_r[0] <= rd_col_r;
            for (int i = 1; i < ED_LAT; i++) begin
                dl_vld_r[i] <= dl_vld_r[i-1];
                dl_row_r[i] <= dl_row_r[i-1];
                dl_col_r[i] <= dl_col_r[i-1];
            end
        end else begin
            dl_vld_r <= dl_vld_r;
        end
    end

    // Handshake flags: busy tracks any non-idle state, done marks entry into DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

    // Completed-frame counter, bumped as a non-aborted DONE cycle ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_r <= {FCW{1'b0}};
        end else if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + FC_ONE;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign thr_out   = thr_r;
    assign rd_row    = rd_row_r;
    assign rd_col    = rd_col_r;
    assign rd_valid  = rd_valid_r;
    // A held cycle must never write; the pending entry reappears once hold drops.
    assign wr_en     = dl_vld_r[ED_LAT-1] & ~hold;
    assign wr_row    = dl_row_r[ED_LAT-1];
    assign wr_col    = dl_col_r[ED_LAT-1];
    assign busy      = busy_r;
    assign done      = done_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: doc/edge_tile_scan_ctrl.md
Name: edge_tile_scan_ctrl

Overview:
- Sequences one frame of the 4x4-tiled edge-detection array: 16 `ed_32` instances working in parallel, each covering a 32x32 tile of the 128x128 image.
- Generates the shared tile-local scan coordinate and the read strobe, and latches the threshold for the whole frame.
- Tracks detector latency with a delay line so that output-memory write enables line up with detector outputs.
- Provides start/busy/done handshake, hold (stall), abort and a completed-frame counter. It sits between the host/readout logic and the detector array plus output bit-memory.

Parameters:
- TILE, 32, tile edge length in pixels; scan covers TILE*TILE positions per frame.
- CW, 5, coordinate width, equal to log2(TILE).
- ED_LAT, 1, detector latency in cycles from rd_valid to valid detector output (legal range 1..8).
- FCW, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- T  in  8  edge threshold; captured when start is accepted.
- hold  in  1  stall; freezes scan counters and delay line while high.
- abort  in  1  synchronous frame cancel.
- thr_out  out  8  latched threshold driven to all 16 detector t inputs.
- rd_row  out  CW  tile-local row i1 presented to the window fetch.
- rd_col  out  CW  tile-local column j1 presented to the window fetch.
- rd_valid  out  1  rd_row/rd_col are a live issue this cycle.
- wr_en  out  1  write the 16 detector outputs into output memory.
- wr_row  out  CW  tile-local row for the write; delayed copy of rd_row.
- wr_col  out  CW  tile-local column for the write; delayed copy of rd_col.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last write has completed.
- frame_cnt  out  FCW  number of completed frames, wraps modulo 2^FCW.

Behaviour:
- Reset (reset=0, asynchronous) clears every output, the state machine and the delay line:
  - state = IDLE; thr_out=0; rd_row=rd_col=0; rd_valid=0; wr_en=0; wr_row=wr_col=0; busy=0; done=0; frame_cnt=0.
  - Reset released in mid-frame leaves nothing pending and produces no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 at edge k: thr_out<=T, rd_row=rd_col=0, rd_valid<=1, state<=RUN.
  - busy=1 from cycle k+1.
- RUN:
  - Each non-held cycle issues the current (rd_row, rd_col), then advances column-major-inner: rd_col increments; at rd_col=TILE-1 it wraps to 0 and rd_row increments.
  - After issuing (TILE-1, TILE-1): rd_valid<=0, state<=DRAIN. With defaults that is exactly 1024 issues.
- Delay line:
  - ED_LAT stages of {valid, row, col}; its input is {rd_valid and not hold, rd_row, rd_col}.
  - wr_en, wr_row and wr_col come from the last stage.
  - wr_en for issue n is high exactly ED_LAT non-held cycles after issue n.
- DRAIN: stays until the delay line is empty, i.e. the cycle after the last wr_en. Then done<=1 for one cycle and state<=DONE.
- DONE: lasts one cycle.
  - done=1, busy=1, frame_cnt increments in this cycle (FCW-bit wrap: 255 goes to 0).
  - Next state is IDLE; busy=0 in the following cycle.
  - start is ignored in DONE.
- Latency with no hold: start edge k → first wr_en at cycle k+1+ED_LAT → last wr_en at k+1024+ED_LAT → done at k+1025+ED_LAT.
- hold=1:
  - Counters, rd_valid, delay line and FSM all freeze.
  - rd_valid stays visible, but no issue is counted, and wr_en is forced to 0 in held cycles.
  - A write that was pending re-appears on the first non-held cycle.
  - hold in IDLE has no effect; start is still accepted.
- abort=1 in RUN, DRAIN or DONE:
  - Next cycle: state=IDLE; delay line, rd_valid and wr_en cleared; busy=0.
  - No done pulse, frame_cnt unchanged, thr_out retains its value.
- Priority: abort > hold > normal progression. start in the same cycle as abort in IDLE is ignored.
- start while busy is ignored and not queued.
- T changes during a frame do not affect thr_out.

Test Plan:
- Basic frame: reset low for 3 cycles; start=1 with T=8'd40 at edge 0, ED_LAT=1, no hold → exactly 1024 wr_en pulses; first write (0,0) at cycle 2, last write (31,31) at cycle 1025; done at cycle 1026; frame_cnt=1; thr_out=40 throughout.
- Ordering: record wr_row/wr_col over the frame → sequence is (0,0),(0,1)…(0,31),(1,0)…(31,31); no gaps or duplicates.
- Hold: assert hold for 10 cycles at issue 500 and for 5 cycles during DRAIN → still 1024 writes in the same order; done delayed by exactly 15 cycles (cycle 1041).
- Abort: abort at cycle 300 → busy=0 by cycle 301; no further wr_en; no done; frame_cnt unchanged. A new start then yields a full 1024-write frame.
- Ignored requests: start pulses during RUN and DONE, and T toggling mid-frame → single frame only; thr_out holds its captured value.
- Async reset and wrap: drop reset mid-DRAIN → all outputs 0 immediately. Run 256 back-to-back frames → frame_cnt wraps to 0. Sweep ED_LAT=4 → done at start+1029.
